// File: rtl/buzzer_note_player.sv
// Plays one note command at a time as a square wave for dur ms, then a silent GAP_MS gap.
// Latency: handshake N, LOAD N+1, tone from N+2; cmd_ready low while busy or stop. Optional BUZZER_DUTY_EN adds duty_sel.
module buzzer_note_player #(
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter int FREQ_W       = 14,
    parameter int DUR_W        = 12,
    parameter int GAP_MS       = 10
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic [FREQ_W-1:0] cmd_freq,
    input  logic [DUR_W-1:0]  cmd_dur,
    input  logic              cmd_valid,
    output logic              cmd_ready,
`ifdef BUZZER_DUTY_EN
    input  logic [1:0]        duty_sel,
`endif
    input  logic              stop,
    output logic              busy,
    output logic              note_done,
    output logic              buzzer_out
);

    localparam int CNT_W = $clog2(SYS_CLK_FREQ);
    localparam int CPM   = SYS_CLK_FREQ / 1000;
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(CPM - 1);
    localparam logic [DUR_W-1:0] GAP_LAST   = (GAP_MS > 0) ? DUR_W'(GAP_MS - 1) : '0;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t             state_q, state_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   half_q, half_d;
    logic [CNT_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]   presc_q, presc_d;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic               buzzer_q, buzzer_d;
    logic               note_done_q, note_done_d;
    logic               busy_q, busy_d;
    logic               cmd_ready_q, cmd_ready_d;
`ifdef BUZZER_DUTY_EN
    logic [1:0]         duty_q, duty_d;
`endif

    logic        ms_tick;
    logic        gap_done;
    logic [31:0] divisor;
    logic [31:0] quot;
    logic [31:0] period_calc;
    logic [31:0] half_calc;

    assign ms_tick  = (presc_q == PRESC_LAST);
    assign gap_done = (GAP_MS == 0) || (ms_tick && (dur_cnt_q == GAP_LAST));

    // Period/half computed from the latched command; a rest uses a dummy divisor.
    always_comb begin
        divisor     = (freq_q == '0) ? 32'd1 : 32'(freq_q);
        quot        = 32'(SYS_CLK_FREQ) / divisor;
        period_calc = (32'(freq_q) > 32'(SYS_CLK_FREQ / 2)) ? 32'd2 : quot;
`ifdef BUZZER_DUTY_EN
        half_calc   = period_calc >> ({30'd0, duty_q} + 32'd1);
`else
        half_calc   = period_calc >> 1;
`endif
        if (half_calc == 32'd0) begin
            half_calc = 32'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        freq_d      = freq_q;
        dur_d       = dur_q;
        period_d    = period_q;
        half_d      = half_q;
        pc_d        = pc_q;
        presc_d     = presc_q;
        dur_cnt_d   = dur_cnt_q;
        buzzer_d    = 1'b0;
        note_done_d = 1'b0;
`ifdef BUZZER_DUTY_EN
        duty_d      = duty_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q && !stop) begin
                    freq_d  = cmd_freq;
                    dur_d   = cmd_dur;
`ifdef BUZZER_DUTY_EN
                    duty_d  = duty_sel;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                period_d  = period_calc[CNT_W-1:0];
                half_d    = half_calc[CNT_W-1:0];
                pc_d      = '0;
                presc_d   = '0;
                dur_cnt_d = '0;
                if (dur_q == '0) begin
                    state_d = GAP;
                end else begin
                    state_d  = PLAY;
                    buzzer_d = (freq_q != '0);
                end
            end
            PLAY: begin
                presc_d = ms_tick ? '0 : presc_q + CNT_W'(1);
                pc_d    = (pc_q == period_q - CNT_W'(1)) ? '0 : pc_q + CNT_W'(1);
                if (ms_tick) begin
                    if (dur_cnt_q + DUR_W'(1) == dur_q) begin
                        state_d   = GAP;
                        dur_cnt_d = '0;
                        pc_d      = '0;
                    end else begin
                        dur_cnt_d = dur_cnt_q + DUR_W'(1);
                    end
                end
                buzzer_d = (state_d == PLAY) && (freq_q != '0) && (pc_d < half_q);
            end
            GAP: begin
                presc_d = ms_tick ? '0 : presc_q + CNT_W'(1);
                if (gap_done) begin
                    state_d     = IDLE;
                    note_done_d = 1'b1;
                    presc_d     = '0;
                    dur_cnt_d   = '0;
                end else if (ms_tick) begin
                    dur_cnt_d = dur_cnt_q + DUR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort silences the pin at once and never reports completion.
        if (stop && (state_q != IDLE)) begin
            state_d     = IDLE;
            pc_d        = '0;
            presc_d     = '0;
            dur_cnt_d   = '0;
            buzzer_d    = 1'b0;
            note_done_d = 1'b0;
        end

        busy_d      = (state_d != IDLE);
        cmd_ready_d = (state_d == IDLE) && !stop;
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q     <= IDLE;
            freq_q      <= '0;
            dur_q       <= '0;
            period_q    <= '0;
            half_q      <= '0;
            pc_q        <= '0;
            presc_q     <= '0;
            dur_cnt_q   <= '0;
            buzzer_q    <= 1'b0;
            note_done_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
`ifdef BUZZER_DUTY_EN
            duty_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            freq_q      <= freq_d;
            dur_q       <= dur_d;
            period_q    <= period_d;
            half_q      <= half_d;
            pc_q        <= pc_d;
            presc_q     <= presc_d;
            dur_cnt_q   <= dur_cnt_d;
            buzzer_q    <= buzzer_d;
            note_done_q <= note_done_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef BUZZER_DUTY_EN
            duty_q      <= duty_d;
`endif
        end
    end

    assign buzzer_out = buzzer_q;
    assign note_done  = note_done_q;
    assign busy       = busy_q;
    assign cmd_ready  = cmd_ready_q;

endmodule

// File: tb/tb_buzzer_note_player.sv
// Directed bench: u_a runs at 1 MHz with a 2 ms gap, u_b at 1 kHz with no gap for clamp cases.
module tb_buzzer_note_player;

    logic        clk = 1'b0;
    logic        reset_p;
    logic [13:0] cmd_freq;
    logic [11:0] cmd_dur;
    logic        valid_a, valid_b, stop;
    logic [1:0]  duty;
    logic        rdy_a, busy_a, done_a, buz_a;
    logic        rdy_b, busy_b, done_b, buz_b;

    always #5 clk = ~clk;

    buzzer_note_player #(.SYS_CLK_FREQ(1_000_000), .FREQ_W(14), .DUR_W(12), .GAP_MS(2)) u_a (
        .clk(clk), .reset_p(reset_p), .cmd_freq(cmd_freq), .cmd_dur(cmd_dur),
        .cmd_valid(valid_a), .cmd_ready(rdy_a),
`ifdef BUZZER_DUTY_EN
        .duty_sel(duty),
`endif
        .stop(stop), .busy(busy_a), .note_done(done_a), .buzzer_out(buz_a));

    buzzer_note_player #(.SYS_CLK_FREQ(1000), .FREQ_W(14), .DUR_W(12), .GAP_MS(0)) u_b (
        .clk(clk), .reset_p(reset_p), .cmd_freq(cmd_freq), .cmd_dur(cmd_dur),
        .cmd_valid(valid_b), .cmd_ready(rdy_b),
`ifdef BUZZER_DUTY_EN
        .duty_sel(duty),
`endif
        .stop(stop), .busy(busy_b), .note_done(done_b), .buzzer_out(buz_b));

    int   sel;
    logic obs_buz, obs_done, obs_busy, obs_rdy;
    assign obs_buz  = (sel == 1) ? buz_b  : buz_a;
    assign obs_done = (sel == 1) ? done_b : done_a;
    assign obs_busy = (sel == 1) ? busy_b : busy_a;
    assign obs_rdy  = (sel == 1) ? rdy_b  : rdy_a;

    int checks = 0;
    int failures = 0;
    int c, hi_cnt, rises, first_rise, second_rise, first_fall, done_c, done_cnt, done_seen;
    logic busy_at_done, ready_at_done, prev_b;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        c++;
    endtask

    // Present one command on the selected instance; returns in the LOAD cycle (c=1).
    task automatic send(input int sel_i, input int f, input int d);
        int w;
        w = 0;
        sel = sel_i;
        #0;
        while (!obs_rdy && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("send_ready", obs_rdy, 1);
        cmd_freq = 14'(f);
        cmd_dur  = 12'(d);
        if (sel_i == 1) valid_b = 1'b1;
        else            valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        c = 1;
    endtask

    task automatic run(input int budget);
        hi_cnt = 0; rises = 0; first_rise = -1; second_rise = -1; first_fall = -1;
        done_c = -1; done_cnt = 0; busy_at_done = 1'bx; ready_at_done = 1'bx;
        prev_b = obs_buz;
        while (c < budget && (done_c < 0 || c < done_c + 3)) begin
            step();
            if (obs_buz) hi_cnt++;
            if (obs_buz && !prev_b) begin
                rises++;
                if (first_rise < 0) first_rise = c;
                else if (second_rise < 0) second_rise = c;
            end
            if (!obs_buz && prev_b && first_fall < 0) first_fall = c;
            if (obs_done) begin
                done_cnt++;
                if (done_c < 0) begin
                    done_c = c;
                    busy_at_done = obs_busy;
                    ready_at_done = obs_rdy;
                end
            end
            prev_b = obs_buz;
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog got=%0d exp=%0d", 0, 1);
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0; c = 0; cmd_freq = '0; cmd_dur = '0; valid_a = 0; valid_b = 0;
        stop = 0; duty = 2'd0; reset_p = 1'b1;
        step();
        chk("rst_buz", buz_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ready", rdy_a, 1);
        chk("rst_done", done_a, 0);
        step(); step();
        reset_p = 1'b0;
        step();

        send(0, 1000, 3);
        chk("load_busy", busy_a, 1);
        chk("load_ready", rdy_a, 0);
        run(8000);
        chk("t1k_first_rise", first_rise, 2);
        chk("t1k_first_fall", first_fall, 502);
        chk("t1k_second_rise", second_rise, 1002);
        chk("t1k_rises", rises, 3);
        chk("t1k_high", hi_cnt, 1500);
        chk("t1k_done_cyc", done_c, 5002);
        chk("t1k_done_cnt", done_cnt, 1);
        chk("t1k_busy_at_done", busy_at_done, 0);
        chk("t1k_ready_at_done", ready_at_done, 1);

        send(0, 0, 5);
        run(9000);
        chk("rest_high", hi_cnt, 0);
        chk("rest_done_cyc", done_c, 7002);
        chk("rest_done_cnt", done_cnt, 1);

        send(0, 16000, 1);
        run(4000);
        chk("t16k_first_fall", first_fall, 33);
        chk("t16k_second_rise", second_rise, 64);
        chk("t16k_rises", rises, 17);
        chk("t16k_high", hi_cnt, 504);
        chk("t16k_done_cyc", done_c, 3002);

        send(0, 1000, 0);
        run(4000);
        chk("dur0_high", hi_cnt, 0);
        chk("dur0_done_cyc", done_c, 2002);

        send(1, 600, 4);
        run(50);
        chk("clamp_high", hi_cnt, 2);
        chk("clamp_rises", rises, 2);
        chk("clamp_first_fall", first_fall, 3);
        chk("clamp_second_rise", second_rise, 4);
        chk("clamp_done_cyc", done_c, 7);

        send(1, 300, 6);
        run(50);
        chk("p3_high", hi_cnt, 2);
        chk("p3_first_fall", first_fall, 3);
        chk("p3_second_rise", second_rise, 5);
        chk("p3_done_cyc", done_c, 9);

        send(0, 1000, 3);
        while (c < 1202) step();
        chk("stop_pre_buz", buz_a, 1);
        stop = 1'b1;
        cmd_freq = 14'd1000;
        cmd_dur = 12'd1;
        valid_a = 1'b1;
        step();
        chk("stop_busy", busy_a, 0);
        chk("stop_buz", buz_a, 0);
        chk("stop_ready", rdy_a, 0);
        done_seen = int'(done_a);
        for (int i = 0; i < 3; i++) begin
            step();
            done_seen += int'(done_a);
            chk("stop_hold_busy", busy_a, 0);
        end
        stop = 1'b0;
        step();
        chk("stop_release_ready", rdy_a, 1);
        done_seen += int'(done_a);
        step();
        valid_a = 1'b0;
        chk("pending_accept_busy", busy_a, 1);
        chk("stop_no_done", done_seen, 0);
        c = 1;
        run(4000);
        chk("pending_done_cyc", done_c, 3002);

        send(0, 1000, 3);
        while (c < 10) step();
        chk("rst_pre_buz", buz_a, 1);
        reset_p = 1'b1;
        step();
        chk("midrst_buz", buz_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_ready", rdy_a, 1);
        chk("midrst_done", done_a, 0);
        step(); step();
        reset_p = 1'b0;
        step();
        chk("postrst_busy", busy_a, 0);

`ifdef BUZZER_DUTY_EN
        duty = 2'd2;
        send(0, 1000, 1);
        run(4000);
        chk("duty_high", hi_cnt, 125);
        chk("duty_first_fall", first_fall, 127);
        chk("duty_done_cyc", done_c, 3002);
        duty = 2'd0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
